guitar_note_gen: RTL and testbench



---
 rtl/guitar_note_gen.sv | 150 +++++++++++++++
 tb/tb_guitar_note_gen.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/guitar_note_gen.sv
// guitar_note_gen: phase-accumulator oscillator with ADSR envelope.
// Define NOTE_GEN_SQUARE_EN for a square wave instead of a sawtooth.
module guitar_note_gen #(
   parameter int SAMPLE_DIV   = 1134,
   parameter int ATTACK_STEP  = 8,
   parameter int DECAY_STEP   = 1,
   parameter int SUSTAIN_LVL  = 160,
   parameter int RELEASE_STEP = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        note_on,
   input  logic        note_off,
   input  logic [23:0] phase_inc,
   output logic [15:0] sample_out,
   output logic        sample_valid,
   output logic        busy
);

   localparam int CW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_DIV - 1);
   localparam logic [8:0] ATK9 = 9'(ATTACK_STEP);
   localparam logic [8:0] DEC9 = 9'(DECAY_STEP);
   localparam logic [8:0] SUS9 = 9'(SUSTAIN_LVL);
   localparam logic [8:0] REL9 = 9'(RELEASE_STEP);

   typedef enum logic [2:0] {
      IDLE,
      ATTACK,
      DECAY,
      SUSTAIN,
      RELEASE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [23:0]   phase_q, phase_d;
   logic [23:0]   inc_q, inc_d;
   logic [7:0]    env_q, env_d;
   logic [15:0]   sample_q, sample_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;

   logic          tick;
   logic [15:0]   wave;
   logic [23:0]   prod;
   logic [8:0]    sum9;
   logic [8:0]    dif_dec9;
   logic [8:0]    dif_rel9;

   // Oscillator shape and amplitude scaling of the current (pre-update) state
   always_comb begin
      tick = (cnt_q == CNT_MAX);
`ifdef NOTE_GEN_SQUARE_EN
      wave = phase_q[23] ? 16'hFFFF : 16'h0000;
`else
      wave = phase_q[23:8];
`endif
      prod     = 24'(wave) * 24'(env_q);
      sum9     = {1'b0, env_q} + ATK9;
      dif_dec9 = {1'b0, env_q} - DEC9;
      dif_rel9 = {1'b0, env_q} - REL9;
   end

   // Next-state: tick counter, envelope step, phase, then note events on top
   always_comb begin
      cnt_d    = tick ? '0 : cnt_q + CW'(1);
      state_d  = state_q;
      env_d    = env_q;
      phase_d  = phase_q;
      inc_d    = inc_q;
      sample_d = sample_q;
      valid_d  = tick;

      if (tick) begin
         sample_d = 16'(prod >> 8);
         phase_d  = phase_q + inc_q;
         unique case (state_q)
            IDLE: env_d = 8'd0;
            ATTACK: begin
               if (sum9 >= 9'd255) begin
                  env_d   = 8'd255;
                  state_d = DECAY;
               end else begin
                  env_d = sum9[7:0];
               end
            end
            DECAY: begin
               if (dif_dec9[8] || dif_dec9 <= SUS9) begin
                  env_d   = SUS9[7:0];
                  state_d = SUSTAIN;
               end else begin
                  env_d = dif_dec9[7:0];
               end
            end
            SUSTAIN: env_d = env_q;
            RELEASE: begin
               if (dif_rel9[8] || dif_rel9 == 9'd0) begin
                  env_d   = 8'd0;
                  state_d = IDLE;
               end else begin
                  env_d = dif_rel9[7:0];
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Events override the tick's state change; env keeps the old-state step
      if (note_on) begin
         state_d = ATTACK;
         phase_d = 24'd0;
         inc_d   = phase_inc;
      end else if (note_off &&
                   (state_q == ATTACK || state_q == DECAY ||
                    state_q == SUSTAIN)) begin
         state_d = RELEASE;
      end

      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         phase_q  <= 24'd0;
         inc_q    <= 24'd0;
         env_q    <= 8'd0;
         sample_q <= 16'd0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
         inc_q    <= inc_d;
         env_q    <= env_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
      end
   end

   assign sample_out   = sample_q;
   assign sample_valid = valid_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_guitar_note_gen.sv
// tb_guitar_note_gen: scoreboard bench for guitar_note_gen.
// Expected samples are queued by stimulus and checked by a monitor.
module tb_guitar_note_gen;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        note_on;
   logic        note_off;
   logic [23:0] phase_inc;
   logic [15:0] sample_out;
   logic        sample_valid;
   logic        busy;

   int tests = 0;
   int fails = 0;
   int exp_q[$];
   int nsamp = 0;
   int gap = -1;

`ifdef NOTE_GEN_SQUARE_EN
   int atk[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
   int rel[2] = '{0, 0};
   int wrp[7] = '{0, 65279, 0, 57087, 0, 51199, 0};
`else
   int atk[9] = '{0, 64, 256, 576, 1020, 1195, 1338, 1449, 1600};
   int rel[2] = '{1800, 1000};
   int wrp[7] = '{0, 32640, 0, 28544, 0, 25600, 0};
`endif

   always #5 clk = ~clk;

   guitar_note_gen #(
      .SAMPLE_DIV  (DIV),
      .ATTACK_STEP (64),
      .DECAY_STEP  (16),
      .SUSTAIN_LVL (200),
      .RELEASE_STEP(100)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .note_on     (note_on),
      .note_off    (note_off),
      .phase_inc   (phase_inc),
      .sample_out  (sample_out),
      .sample_valid(sample_valid),
      .busy        (busy)
   );

   task automatic chk(string name, int got, int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   // Monitor: strobe spacing and scoreboard pop on every sample strobe
   always @(negedge clk) begin
      if (rst) begin
         gap = -1;
         chk("strobe_in_reset", int'(sample_valid === 1'b1), 0);
      end else begin
         gap++;
         if (sample_valid) begin
            chk("strobe_gap", gap, DIV);
            gap = 0;
            chk("sb_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0)
               chk($sformatf("sample%0d", nsamp), int'(sample_out),
                   exp_q.pop_front());
            nsamp++;
         end
      end
   end

   task automatic step(int e);
      bit seen;
      seen = 1'b0;
      exp_q.push_back(e);
      for (int i = 0; i < 3 * DIV && !seen; i++) begin
         @(negedge clk);
         if (sample_valid) seen = 1'b1;
      end
      if (!seen) begin
         tests++;
         fails++;
         $display("FAIL strobe_timeout got none expected strobe");
      end
   endtask

   task automatic ev(bit on, bit off, logic [23:0] inc,
                     int busy_pre, int busy_post);
      @(posedge clk);
      #1;
      note_on   = on;
      note_off  = off;
      phase_inc = inc;
      @(negedge clk);
      chk("busy_pre", int'(busy), busy_pre);
      @(posedge clk);
      #1;
      note_on  = 1'b0;
      note_off = 1'b0;
      @(negedge clk);
      chk("busy_post", int'(busy), busy_post);
   endtask

   initial begin
      rst       = 1'b1;
      note_on   = 1'b0;
      note_off  = 1'b0;
      phase_inc = 24'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_sample", int'(sample_out), 0);
      chk("rst_valid", int'(sample_valid), 0);
      chk("rst_busy", int'(busy), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rel_sample", int'(sample_out), 0);
      chk("rel_busy", int'(busy), 0);

      step(0);
      step(0);

      ev(1'b1, 1'b0, 24'h010000, 0, 1);
      for (int i = 0; i < 9; i++) step(atk[i]);
      chk("sustain_busy", int'(busy), 1);

      ev(1'b0, 1'b1, 24'h000000, 1, 1);
      step(rel[0]);
      chk("release_busy", int'(busy), 1);
      step(rel[1]);
      chk("idle_busy", int'(busy), 0);
      step(0);
      step(0);

      ev(1'b1, 1'b0, 24'h010000, 0, 1);
      for (int i = 0; i < 9; i++) step(atk[i]);

      ev(1'b1, 1'b1, 24'h800000, 1, 1);
      for (int i = 0; i < 7; i++) step(wrp[i]);
      chk("wrap_busy", int'(busy), 1);

      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_sample", int'(sample_out), 0);
      chk("midrst_valid", int'(sample_valid), 0);
      chk("midrst_busy", int'(busy), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(0);
      step(0);
      chk("post_busy", int'(busy), 0);

      repeat (2) @(negedge clk);
      chk("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
